ccff_chain_loader: RTL
======================

// Module: ccff_chain_loader
// PURPOSE
//   Drives the configuration-chain head (ccff_head) of a tile column/row and gates prog_clk to it.
//   Takes bitstream bytes from the host side over a valid/ready stream and serialises them into the chain.
//   Captures ccff_tail as it shifts, so the previous chain contents are read back byte-wise for verify.
//   Sits directly upstream of the connection/switch-block ccff chain.
// PARAMETERS
//   CHAIN_LEN  50  total config bits in the downstream chain (one cbx: 10 muxes x 5 bits)
//   DATA_W     8   host stream byte width
//   CNT_W      $clog2(CHAIN_LEN+1)  bit-counter width (derived, not overridden)
// PORTS
//   prog_clk      in   1       config clock, single clock domain
//   prog_reset_n  in   1       asynchronous, active-low reset
//   start         in   1       1-cycle pulse: begin a full-chain load
//   s_data        in   DATA_W  bitstream byte; bit 0 enters the chain first
//   s_valid       in   1       s_data valid
//   s_ready       out  1       loader accepts s_data this cycle
//   ccff_head     out  1       serial bit to chain head
//   ccff_clk_en   out  1       enable for external prog_clk gate feeding the chain (1 = chain shifts this edge)
//   ccff_tail     in   1       serial bit from chain tail
//   rb_data       out  DATA_W  readback byte (tail bits, first-out in bit 0)
//   rb_valid      out  1       1-cycle pulse, rb_data valid; no backpressure
//   busy          out  1       load in progress
//   done          out  1       chain fully loaded; held until next start
// BEHAVIOUR
//   Reset (async, any cycle): state=IDLE; all outputs 0; bit counter=CHAIN_LEN; shift regs cleared.
//   FSM: IDLE -start-> FETCH; FETCH -(s_valid&s_ready)-> SHIFT; SHIFT -(byte done, bits left>0)-> FETCH;
//        SHIFT -(bits left==0)-> DONE; DONE -start-> FETCH (done cleared same edge).
//   FETCH: s_ready=1, ccff_clk_en=0; on handshake load data shreg, byte_bits=min(8, bits_left).
//   SHIFT: each cycle ccff_head=shreg[0], ccff_clk_en=1; on edge: shreg>>=1, rb_shreg={ccff_tail,rb_shreg[7:1]},
//          bits_left-=1, byte_bits-=1. ccff_head/ccff_clk_en registered; stable for the whole cycle they assert.
//   Partial last byte (CHAIN_LEN%8!=0): only remaining bits shifted; upper bits of that byte discarded;
//     rb_data right-justified into bit 0 (unused MSBs = 0).
//   rb_valid pulses the cycle after the last shift of each byte; rb_data holds until next pulse.
//   Throughput: 1 handshake cycle + byte_bits shift cycles per byte; s_ready=0 in SHIFT, IDLE, DONE.
//   busy=1 in FETCH and SHIFT; done=1 only in DONE.
//   start while busy: ignored. start in IDLE or DONE: restarts with bits_left=CHAIN_LEN.
//   s_valid in IDLE/DONE: not accepted (s_ready=0), data stays with host.
//   Reset mid-load: ccff_clk_en drops immediately; chain contents undefined; a new full load is required.
//   Counter never wraps: bits_left saturates at 0, which forces exit to DONE.
// STRUCTURE
//   ccff_loader_pkg: state enum {IDLE, FETCH, SHIFT, DONE}; default CHAIN_LEN; byte width constant.
//   Single module, no sub-modules; external clock-gate cell (ICG) lives at the tile top, not here.
// TESTING
//   1 Reset: hold prog_reset_n=0 with s_valid=1 -> s_ready/ccff_clk_en/busy/done/rb_valid all 0.
//   2 Full load CHAIN_LEN=50, bytes 0xA5,0x3C,0xFF,0x00,0x81,0x7E,0x02 -> exactly 50 ccff_clk_en cycles;
//       downstream model chain holds bits LSB-first; last byte only bits[1:0] used; done=1.
//   3 Readback: preload chain model with known 50-bit pattern, load 7 zero bytes -> rb_valid x7,
//       rb_data returns pattern LSB-first; 7th byte = 2 bits in [1:0], [7:2]=0.
//   4 Backpressure: s_valid low for 5 cycles between bytes -> ccff_clk_en stays 0, no extra shift, bit count exact.
//   5 start asserted mid-load at bit 20 -> ignored, load completes at 50; start in DONE -> done clears, reload 50 bits.
//   6 Reset asserted at bit 33 -> outputs 0 same cycle; after release with no start, 0 further shifts.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and defaults for the configuration-chain loader.
// Holds the FSM state encoding and the default chain geometry.
package ccff_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_e;

   // One cbx: 10 muxes x 5 config bits.
   localparam int unsigned CHAIN_LEN_DEF = 50;
   localparam int unsigned BYTE_W        = 8;

endpackage

// File: rtl/ccff_chain_loader.sv
// Serialises host bitstream bytes into a ccff chain head and gates its prog_clk,
// capturing the tail bits as they shift out for byte-wise readback.
module ccff_chain_loader
   import ccff_loader_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF,
   parameter int unsigned DATA_W    = BYTE_W
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              start,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              ccff_head,
   output logic              ccff_clk_en,
   input  logic              ccff_tail,
   output logic [DATA_W-1:0] rb_data,
   output logic              rb_valid,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int unsigned BB_W  = $clog2(DATA_W + 1);

   state_e            state_q,     state_d;
   logic [DATA_W-1:0] shreg_q,     shreg_d;
   logic [DATA_W-1:0] rb_shreg_q,  rb_shreg_d;
   logic [DATA_W-1:0] rb_data_q,   rb_data_d;
   logic              rb_valid_q,  rb_valid_d;
   logic [CNT_W-1:0]  bits_left_q, bits_left_d;
   logic [BB_W-1:0]   byte_bits_q, byte_bits_d;
   logic [BB_W-1:0]   byte_len_q,  byte_len_d;
   logic              head_q,      head_d;
   logic              clk_en_q,    clk_en_d;
   logic [BB_W-1:0]   take;
   logic              last_shift;

   // Bits taken from the next byte: a full byte, or whatever is left of the chain.
   always_comb begin
      if (bits_left_q >= CNT_W'(DATA_W)) begin
         take = BB_W'(DATA_W);
      end else begin
         take = BB_W'(bits_left_q);
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no latch can be inferred.
      state_d     = state_q;
      shreg_d     = shreg_q;
      rb_shreg_d  = rb_shreg_q;
      rb_data_d   = rb_data_q;
      rb_valid_d  = 1'b0;
      bits_left_d = bits_left_q;
      byte_bits_d = byte_bits_q;
      byte_len_d  = byte_len_q;
      last_shift  = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = FETCH;
               bits_left_d = CNT_W'(CHAIN_LEN);
            end
         end
         FETCH: begin
            if (s_valid) begin
               state_d     = SHIFT;
               shreg_d     = s_data;
               rb_shreg_d  = '0;
               byte_bits_d = take;
               byte_len_d  = take;
            end
         end
         SHIFT: begin
            shreg_d    = shreg_q >> 1;
            rb_shreg_d = {ccff_tail, rb_shreg_q[DATA_W-1:1]};
            bits_left_d = (bits_left_q != '0) ? bits_left_q - CNT_W'(1) : '0;
            byte_bits_d = (byte_bits_q != '0) ? byte_bits_q - BB_W'(1) : '0;
            last_shift  = (bits_left_d == '0) || (byte_bits_q <= BB_W'(1));
            if (last_shift) begin
               rb_valid_d = 1'b1;
               // Tail bits enter at the MSB; right-justify a partial byte into bit 0.
               rb_data_d  = rb_shreg_d >> (BB_W'(DATA_W) - byte_len_q);
               state_d    = (bits_left_d == '0) ? DONE : FETCH;
            end
         end
         default: state_d = IDLE;
      endcase

      clk_en_d = (state_d == SHIFT);
      head_d   = clk_en_d & shreg_d[0];
   end

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         rb_shreg_q  <= '0;
         rb_data_q   <= '0;
         rb_valid_q  <= 1'b0;
         bits_left_q <= CNT_W'(CHAIN_LEN);
         byte_bits_q <= '0;
         byte_len_q  <= '0;
         head_q      <= 1'b0;
         clk_en_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         rb_shreg_q  <= rb_shreg_d;
         rb_data_q   <= rb_data_d;
         rb_valid_q  <= rb_valid_d;
         bits_left_q <= bits_left_d;
         byte_bits_q <= byte_bits_d;
         byte_len_q  <= byte_len_d;
         head_q      <= head_d;
         clk_en_q    <= clk_en_d;
      end
   end

   assign s_ready     = (state_q == FETCH);
   assign busy        = (state_q == FETCH) || (state_q == SHIFT);
   assign done        = (state_q == DONE);
   assign ccff_head   = head_q;
   assign ccff_clk_en = clk_en_q;
   assign rb_data     = rb_data_q;
   assign rb_valid    = rb_valid_q;

endmodule
